ntt_batch_stream_ctrl: RTL and testbench

Batch streaming controller that feeds one or more length-2^LOGN polynomials from an input BRAM into an external SDF NTT/INTT pipeline and writes the results back to an output BRAM. It supersedes the single-polynomial wrapper: it adds a configurable batch count, a selectable output ordering (bit-reversed or natural), a start/busy/done handshake, re-arming for back-to-back jobs, and an overflow flag. It sits between the coefficient BRAMs and `ntt_sdf_wrapper` in the SDF datapath top.

---
 rtl/ntt_batch_stream_ctrl.sv | 170 +++++++++++++++++
 tb/tb_ntt_batch_stream_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_batch_stream_ctrl.sv
// Batch streaming controller: reads n polynomials from an input BRAM into an SDF NTT core
// and writes the core results back to an output BRAM, with start/busy/done handshake.
module ntt_batch_stream_ctrl #(
    parameter int LOGN        = 10,
    parameter int LOGQ        = 64,
    parameter int NUM_POLY    = 4,
    parameter int PW          = (NUM_POLY > 1) ? $clog2(NUM_POLY) : 1,
    parameter int ADDRW       = PW + LOGN,
    parameter int START_DELAY = 10,
    parameter int DELAY_BRAM  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             intt,
    input  logic             bitrev_out,
    input  logic [PW:0]      num_poly,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             rd_en,
    output logic [ADDRW-1:0] rd_addr,
    input  logic [LOGQ-1:0]  rd_data,
    output logic             core_start,
    output logic             core_intt,
    output logic [LOGQ-1:0]  core_in,
    input  logic             core_valid,
    input  logic [LOGQ-1:0]  core_out,
    output logic             wr_en,
    output logic [ADDRW-1:0] wr_addr,
    output logic [LOGQ-1:0]  wr_data
);

    localparam int CW  = ADDRW + 1;
    localparam int DCW = (START_DELAY < 2) ? 1 : $clog2(START_DELAY + 1);
    localparam logic [PW:0] NP_MAX = (PW + 1)'(NUM_POLY);

    typedef enum logic [2:0] {S_IDLE, S_PRIME, S_STREAM, S_DRAIN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [DCW-1:0]        dcnt_q, dcnt_d;
    logic [CW-1:0]         rcnt_q, rcnt_d;
    logic [CW-1:0]         wcnt_q, wcnt_d;
    logic [CW-1:0]         total_q, total_d;
    logic                  intt_q, intt_d;
    logic                  bitrev_q, bitrev_d;
    logic                  ovf_q, ovf_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  rd_en_q, rd_en_d;
    logic                  cs_q, cs_d;
    logic [DELAY_BRAM-1:0] pipe_q, pipe_d;
    logic [PW:0]           n_clamp;
    logic                  write_ok;
    logic                  wr_fire;

    function automatic logic [LOGN-1:0] bit_reverse(input logic [LOGN-1:0] v);
        logic [LOGN-1:0] r;
        for (int i = 0; i < LOGN; i++) begin
            r[i] = v[LOGN-1-i];
        end
        return r;
    endfunction

    always_comb begin
        n_clamp  = (num_poly == '0 || num_poly > NP_MAX) ? NP_MAX : num_poly;
        write_ok = (state_q == S_STREAM || state_q == S_DRAIN) && (wcnt_q < total_q);
        wr_fire  = core_valid && write_ok;

        state_d  = state_q;
        dcnt_d   = dcnt_q;
        rcnt_d   = rcnt_q;
        total_d  = total_q;
        intt_d   = intt_q;
        bitrev_d = bitrev_q;
        wcnt_d   = wr_fire ? wcnt_q + 1'b1 : wcnt_q;
        ovf_d    = ovf_q | (core_valid & ~write_ok);
        // pipe tracks which cycles carry valid BRAM read data
        pipe_d   = (pipe_q << 1) | DELAY_BRAM'(rd_en_q);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = (START_DELAY == 0) ? S_STREAM : S_PRIME;
                    intt_d   = intt;
                    bitrev_d = bitrev_out;
                    total_d  = {n_clamp, {LOGN{1'b0}}};
                    dcnt_d   = '0;
                    rcnt_d   = '0;
                    wcnt_d   = '0;
                    ovf_d    = 1'b0;
                    pipe_d   = '0;
                end
            end
            S_PRIME: begin
                if (dcnt_q == DCW'(START_DELAY - 1)) begin
                    state_d = S_STREAM;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            S_STREAM: begin
                rcnt_d = rcnt_q + 1'b1;
                if (rcnt_q == total_q - 1'b1) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // the edge that writes the last word also enters DONE
                if (wcnt_d == total_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        rd_en_d = (state_d == S_STREAM);
        cs_d    = (state_d == S_STREAM || state_d == S_DRAIN) && (cs_q || pipe_d[DELAY_BRAM-1]);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            dcnt_q   <= '0;
            rcnt_q   <= '0;
            wcnt_q   <= '0;
            total_q  <= '0;
            intt_q   <= 1'b0;
            bitrev_q <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_en_q  <= 1'b0;
            cs_q     <= 1'b0;
            pipe_q   <= '0;
        end else begin
            state_q  <= state_d;
            dcnt_q   <= dcnt_d;
            rcnt_q   <= rcnt_d;
            wcnt_q   <= wcnt_d;
            total_q  <= total_d;
            intt_q   <= intt_d;
            bitrev_q <= bitrev_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rd_en_q  <= rd_en_d;
            cs_q     <= cs_d;
            pipe_q   <= pipe_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign overflow   = ovf_q;
    assign rd_en      = rd_en_q;
    assign rd_addr    = rd_en_q ? rcnt_q[ADDRW-1:0] : '0;
    assign core_start = cs_q;
    assign core_intt  = intt_q & busy_q;
    assign core_in    = pipe_q[DELAY_BRAM-1] ? rd_data : '0;
    assign wr_en      = wr_fire;
    assign wr_addr    = wr_fire ? {wcnt_q[ADDRW-1:LOGN],
                                   bitrev_q ? bit_reverse(wcnt_q[LOGN-1:0]) : wcnt_q[LOGN-1:0]}
                                : '0;
    assign wr_data    = wr_fire ? core_out : '0;

endmodule

// File: tb/tb_ntt_batch_stream_ctrl.sv
// Bench for ntt_batch_stream_ctrl: BRAM + 20-cycle identity core models, a cycle-window
// reference model checked every cycle, and directed jobs with hand-computed expectations.
module tb_ntt_batch_stream_ctrl;
    localparam int LOGN = 4, LOGQ = 16, NUM_POLY = 4, PW = 2, ADDRW = 6;
    localparam int SD = 10, DB = 2, N = 16, CL = 20;

    logic clk = 1'b0, rst = 1'b0, start = 1'b0, intt = 1'b0, bitrev_out = 1'b0;
    logic [PW:0] num_poly = '0;
    logic busy, done, overflow, rd_en, core_start, core_intt, wr_en, core_valid;
    logic [ADDRW-1:0] rd_addr, wr_addr;
    logic [LOGQ-1:0] rd_data, core_in, core_out, wr_data;

    int total = 0, bad = 0, cyc = 0;

    ntt_batch_stream_ctrl #(
        .LOGN(LOGN), .LOGQ(LOGQ), .NUM_POLY(NUM_POLY),
        .START_DELAY(SD), .DELAY_BRAM(DB)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .intt(intt), .bitrev_out(bitrev_out),
        .num_poly(num_poly), .busy(busy), .done(done), .overflow(overflow),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .core_start(core_start), .core_intt(core_intt), .core_in(core_in),
        .core_valid(core_valid), .core_out(core_out),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [LOGQ-1:0] memf(input int a);
        return LOGQ'(a * 37 + 11) ^ 16'h5a00;
    endfunction

    function automatic int exp_waddr(input int w, input bit br);
        int idx, r;
        idx = w % N;
        r = 0;
        if (br) begin
            for (int b = 0; b < LOGN; b++) r = r * 2 + ((idx >> b) & 1);
        end else begin
            r = idx;
        end
        return (w / N) * N + r;
    endfunction

    // input BRAM with DB-cycle read latency
    logic [ADDRW-1:0] ra [DB] = '{default: '0};
    always @(posedge clk) begin
        ra[0] <= rd_addr;
        for (int i = 1; i < DB; i++) ra[i] <= ra[i-1];
    end
    assign rd_data = memf(int'(ra[DB-1]));

    // identity core with CL-cycle latency
    logic [DB-1:0] dv = '0;
    logic [CL-1:0] cv = '0;
    logic [LOGQ-1:0] cd [CL] = '{default: '0};
    logic inj = 1'b0;
    logic [LOGQ-1:0] inj_data = '0;
    always @(posedge clk) begin
        if (!rst) begin
            dv <= '0;
            cv <= '0;
        end else begin
            dv <= {dv[DB-2:0], rd_en};
            cv <= {cv[CL-2:0], dv[DB-1]};
        end
        cd[0] <= core_in;
        for (int i = 1; i < CL; i++) cd[i] <= cd[i-1];
    end
    assign core_valid = cv[CL-1] | inj;
    assign core_out   = cv[CL-1] ? cd[CL-1] : inj_data;

    // reference model: job windows in absolute cycles
    bit m_act = 0, m_br = 0, m_intt = 0, m_ovf = 0;
    int m_acc = 0, m_T = 0, m_wc = 0, m_done_at = -1;
    always @(negedge clk) begin
        int first;
        bit rd_x, wr_ok, wr_x, cs_x, cin_v, was_idle;
        int np;
        first = m_acc + 1 + SD;
        rd_x  = m_act && cyc >= first && cyc < first + m_T;
        wr_ok = m_act && cyc >= first && m_wc < m_T;
        wr_x  = core_valid && wr_ok;
        cs_x  = m_act && cyc >= first + DB && !(m_done_at >= 0 && cyc >= m_done_at);
        cin_v = m_act && (cyc - DB) >= first && (cyc - DB) < first + m_T;
        chk("busy", busy, m_act);
        chk("done", done, m_act && cyc == m_done_at);
        chk("overflow", overflow, m_ovf);
        chk("rd_en", rd_en, rd_x);
        chk("rd_addr", rd_addr, rd_x ? 64'(cyc - first) : 64'd0);
        chk("core_start", core_start, cs_x);
        chk("core_intt", core_intt, m_act && m_intt);
        chk("core_in", core_in, cin_v ? memf(cyc - DB - first) : '0);
        chk("wr_en", wr_en, wr_x);
        chk("wr_addr", wr_addr, wr_x ? 64'(exp_waddr(m_wc, m_br)) : 64'd0);
        chk("wr_data", wr_data, wr_x ? memf(m_wc) : '0);
        if (!rst) begin
            m_act = 0; m_ovf = 0; m_done_at = -1;
        end else begin
            was_idle = !m_act;
            if (core_valid && !wr_ok) m_ovf = 1;
            if (wr_x) begin
                m_wc++;
                if (m_wc == m_T) m_done_at = cyc + 1;
            end
            if (m_act && cyc == m_done_at) m_act = 0;
            if (was_idle && start) begin
                np = int'(num_poly);
                if (np == 0 || np > NUM_POLY) np = NUM_POLY;
                m_act = 1; m_acc = cyc; m_T = np * N; m_wc = 0; m_done_at = -1;
                m_ovf = 0; m_br = bitrev_out; m_intt = intt;
            end
        end
    end

    // event log for per-job literal checks
    int acc_cyc = 0, acc_cnt = 0, first_rd = -1, done_cnt = 0, done_cyc = 0, prev_done_cyc = 0;
    bit intt_seen = 0;
    int wlog[$], rlog[$];
    always @(negedge clk) begin
        if (rst && start && !busy) begin acc_cyc = cyc; acc_cnt++; end
        if (rd_en) begin
            if (first_rd < 0) begin first_rd = cyc; intt_seen = core_intt; end
            rlog.push_back(int'(rd_addr));
        end
        if (wr_en) wlog.push_back(int'(wr_addr));
        if (done) begin done_cnt++; done_cyc = cyc; end
    end

    task automatic launch(input int np, input bit inv, input bit br);
        @(posedge clk); #1;
        prev_done_cyc = done_cyc;
        wlog.delete(); rlog.delete();
        first_rd = -1; done_cnt = 0; acc_cnt = 0;
        start = 1'b1; num_poly = (PW + 1)'(np); intt = inv; bitrev_out = br;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_job(input int np, input bit inv, input bit br, input bit extra);
        bit seen;
        seen = 0;
        launch(np, inv, br);
        if (extra) begin
            repeat (3) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("done_seen", seen, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bit inorder;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_wr_en", wr_en, 0);

        // single polynomial, bit-reversed writes
        run_job(1, 0, 1, 0);
        @(negedge clk);
        chk("t1_busy_after_done", busy, 0);
        idle(2);
        chk("t1_first_rd_latency", first_rd - acc_cyc, 11);
        chk("t1_wr0", wlog[0], 0);
        chk("t1_wr1", wlog[1], 8);
        chk("t1_wr2", wlog[2], 4);
        chk("t1_wr3", wlog[3], 12);
        chk("t1_wr15", wlog[15], 15);
        chk("t1_nwrites", wlog.size(), 16);
        chk("t1_done_cnt", done_cnt, 1);

        // three polynomials, natural order, inverse mode
        run_job(3, 1, 0, 0);
        idle(3);
        chk("t2_nreads", rlog.size(), 48);
        chk("t2_last_rd", rlog[47], 47);
        chk("t2_nwrites", wlog.size(), 48);
        inorder = 1;
        foreach (wlog[i]) if (wlog[i] != i) inorder = 0;
        chk("t2_wr_inorder", inorder, 1);
        chk("t2_core_intt", intt_seen, 1);
        chk("t2_done_cnt", done_cnt, 1);

        // num_poly clamping
        run_job(0, 0, 0, 0);
        idle(2);
        chk("t3_np0_nwrites", wlog.size(), 64);
        run_job(7, 0, 1, 0);
        idle(2);
        chk("t3_np7_nwrites", wlog.size(), 64);
        chk("t3_np7_last_wr", wlog[63], 63);

        // start while busy, then a stray core_valid after done
        run_job(1, 0, 0, 1);
        idle(2);
        chk("t4_accept_cnt", acc_cnt, 1);
        chk("t4_done_cnt", done_cnt, 1);
        chk("t4_nwrites", wlog.size(), 16);
        @(posedge clk); #1 inj = 1'b1; inj_data = 16'hbeef;
        @(posedge clk); #1 inj = 1'b0;
        idle(2);
        chk("t4_overflow_set", overflow, 1);
        run_job(1, 0, 0, 0);
        idle(2);
        chk("t4_overflow_cleared", overflow, 0);

        // back-to-back jobs
        run_job(2, 0, 1, 0);
        run_job(1, 1, 0, 0);
        idle(2);
        chk("t5_no_gap", acc_cyc, prev_done_cyc + 1);
        chk("t5_rd_restart", rlog[0], 0);
        chk("t5_nwrites", wlog.size(), 16);
        chk("t5_done_cnt", done_cnt, 1);

        // reset during STREAM
        launch(2, 0, 0);
        repeat (15) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("t6_busy", busy, 0);
        chk("t6_rd_en", rd_en, 0);
        chk("t6_rd_addr", rd_addr, 0);
        chk("t6_core_start", core_start, 0);
        chk("t6_wr_en", wr_en, 0);
        chk("t6_done", done, 0);
        chk("t6_overflow", overflow, 0);
        run_job(1, 0, 1, 0);
        idle(3);
        chk("t6_done_cnt", done_cnt, 1);
        chk("t6_nwrites", wlog.size(), 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
